// File: rtl/ov7670_sccb_config.sv
// ov7670_sccb_config: write-only SCCB master that programs the OV7670 register
// table after power-up and raises pronto once every entry has been written.
// Each entry is one 3-phase write: DEVICE_ID, sub-address, data.
// Optional build macro: SCCB_RESET_DELAY_EN adds a 1 ms settle wait (ESPERA)
// after the COM7 soft-reset write (entry 0), counted in system clocks.
//
// state    | code | meaning
// OCIOSO   | 0    | idle, bus high, waiting for iniciar
// START    | 1    | SIOD low with SIOC high for 2 ticks
// BIT      | 2    | one data bit, 4 ticks: SIOC low+drive, hold, SIOC high, hold
// DONTCARE | 3    | 9th bit of a phase, SIOD released, ack ignored
// STOP     | 4    | SIOC low/SIOD low, then SIOC high, then SIOD high
// GAP      | 5    | bus idle between writes
// FIM      | 6    | table written, pronto set, back to OCIOSO next clock
// ESPERA   | 7    | sensor soft-reset settle time (SCCB_RESET_DELAY_EN only)

module ov7670_sccb_config #(
    parameter int         CLK_FREQ  = 50000000,
    parameter int         SCCB_FREQ = 100000,
    parameter logic [7:0] DEVICE_ID = 8'h42,
    parameter int         GAP_TICKS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    output logic       SIOC,
    output logic       SIOD_o,
    output logic       SIOD_oe,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);
    localparam int         Q        = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int         DIV_W    = (Q > 1) ? $clog2(Q) : 1;
    localparam int         CNT_W    = (GAP_TICKS > 4) ? $clog2(GAP_TICKS) : 2;
    localparam logic [2:0] LAST_IDX = 3'd6;
`ifdef SCCB_RESET_DELAY_EN
    localparam int         DELAY_CLKS = CLK_FREQ / 1000;
    localparam int         WAIT_W     = (DELAY_CLKS > 1) ? $clog2(DELAY_CLKS) : 1;
`endif

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        START    = 3'd1,
        BIT      = 3'd2,
        DONTCARE = 3'd3,
        STOP     = 3'd4,
        GAP      = 3'd5,
        FIM      = 3'd6,
        ESPERA   = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [2:0]       idx_q, idx_d;
    logic             sioc_q, sioc_d;
    logic             siod_q, siod_d;
    logic             oe_q, oe_d;
    logic             ocupado_q, ocupado_d;
    logic             pronto_q, pronto_d;
`ifdef SCCB_RESET_DELAY_EN
    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    logic       tick;
    logic [7:0] cur_byte;
    logic [7:0] next_byte;

    // {sub-address, data} for each table entry
    function automatic logic [15:0] table_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    table_entry = 16'h1280;
            3'd1:    table_entry = 16'h1101;
            3'd2:    table_entry = 16'h1214;
            3'd3:    table_entry = 16'h40D0;
            3'd4:    table_entry = 16'h8C00;
            3'd5:    table_entry = 16'h0C04;
            default: table_entry = 16'h3E19;
        endcase
    endfunction

    // byte sent in phase sel (0 = device ID, 1 = sub-address, 2 = data)
    function automatic logic [7:0] phase_byte(input logic [1:0] sel, input logic [2:0] idx);
        logic [15:0] e;
        e = table_entry(idx);
        case (sel)
            2'd0:    phase_byte = DEVICE_ID;
            2'd1:    phase_byte = e[15:8];
            default: phase_byte = e[7:0];
        endcase
    endfunction

    assign tick      = (div_q == DIV_W'(Q - 1));
    assign cur_byte  = phase_byte(byte_q, idx_q);
    assign next_byte = phase_byte(byte_q + 2'd1, idx_q);

    // next-state and next-output computation; every phase step waits for a tick
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        idx_d     = idx_q;
        sioc_d    = sioc_q;
        siod_d    = siod_q;
        oe_d      = oe_q;
        ocupado_d = ocupado_q;
        pronto_d  = pronto_q;
`ifdef SCCB_RESET_DELAY_EN
        wait_d    = wait_q;
`endif

        if (!ocupado_q || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        case (state_q)
            OCIOSO: begin
                if (iniciar) begin
                    state_d   = START;
                    ocupado_d = 1'b1;
                    pronto_d  = 1'b0;
                    idx_d     = '0;
                    cnt_d     = '0;
                    sioc_d    = 1'b1;
                    siod_d    = 1'b0;
                    oe_d      = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = BIT;
                        cnt_d   = '0;
                        bit_d   = 3'd7;
                        byte_d  = 2'd0;
                        sioc_d  = 1'b0;
                        siod_d  = DEVICE_ID[7];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            BIT: begin
                if (tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    case (cnt_q[1:0])
                        2'd1: sioc_d = 1'b1;
                        2'd3: begin
                            cnt_d  = '0;
                            sioc_d = 1'b0;
                            if (bit_q == 3'd0) begin
                                state_d = DONTCARE;
                                oe_d    = 1'b0;
                            end else begin
                                bit_d  = bit_q - 3'd1;
                                siod_d = cur_byte[bit_q - 3'd1];
                            end
                        end
                        default: ;
                    endcase
                end
            end
            DONTCARE: begin
                if (tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    case (cnt_q[1:0])
                        2'd1: sioc_d = 1'b1;
                        2'd3: begin
                            cnt_d  = '0;
                            sioc_d = 1'b0;
                            oe_d   = 1'b1;
                            if (byte_q == 2'd2) begin
                                state_d = STOP;
                                siod_d  = 1'b0;
                            end else begin
                                state_d = BIT;
                                byte_d  = byte_q + 2'd1;
                                bit_d   = 3'd7;
                                siod_d  = next_byte[7];
                            end
                        end
                        default: ;
                    endcase
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    case (cnt_q[1:0])
                        2'd0: sioc_d = 1'b1;
                        2'd1: siod_d = 1'b1;
                        default: begin
                            cnt_d   = '0;
                            state_d = GAP;
`ifdef SCCB_RESET_DELAY_EN
                            if (idx_q == 3'd0) begin
                                state_d = ESPERA;
                                wait_d  = WAIT_W'(DELAY_CLKS - 1);
                            end
`endif
                        end
                    endcase
                end
            end
`ifdef SCCB_RESET_DELAY_EN
            ESPERA: begin
                if (wait_q == '0) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
`endif
            GAP: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(GAP_TICKS - 1)) begin
                        cnt_d = '0;
                        if (idx_q < LAST_IDX) begin
                            idx_d   = idx_q + 3'd1;
                            state_d = START;
                            siod_d  = 1'b0;
                        end else begin
                            state_d   = FIM;
                            ocupado_d = 1'b0;
                            pronto_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FIM:     state_d = OCIOSO;
            default: state_d = OCIOSO;
        endcase
    end

    // state and output registers; reset aborts any write without a stop condition
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= OCIOSO;
            div_q     <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            idx_q     <= '0;
            sioc_q    <= 1'b1;
            siod_q    <= 1'b1;
            oe_q      <= 1'b1;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
`ifdef SCCB_RESET_DELAY_EN
            wait_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            idx_q     <= idx_d;
            sioc_q    <= sioc_d;
            siod_q    <= siod_d;
            oe_q      <= oe_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
`ifdef SCCB_RESET_DELAY_EN
            wait_q    <= wait_d;
`endif
        end
    end

    assign SIOC      = sioc_q;
    assign SIOD_o    = siod_q;
    assign SIOD_oe   = oe_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign db_estado = {1'b0, state_q};

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// tb_ov7670_sccb_config: bench for ov7670_sccb_config with a shortened quarter
// period (Q = 5 clocks). A timeline model derived from the write format
// predicts every output on every clock; a bus decoder rebuilds the SCCB writes
// from SIOC/SIOD and checks them, plus state timing, against the table.

module tb_ov7670_sccb_config;
    localparam int CLK_FREQ  = 2000000;
    localparam int SCCB_FREQ = 100000;
    localparam int Q         = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int GAP_TICKS = 4;
    localparam int WRITE_CLK = 113 * Q;
    localparam int SLOT_CLK  = (113 + GAP_TICKS) * Q;
`ifdef SCCB_RESET_DELAY_EN
    localparam int DELAY_CLK = CLK_FREQ / 1000;
`else
    localparam int DELAY_CLK = 0;
`endif
    localparam int RUN_CLK   = 7 * SLOT_CLK + DELAY_CLK;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       SIOC;
    logic       SIOD_o;
    logic       SIOD_oe;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    ov7670_sccb_config #(
        .CLK_FREQ (CLK_FREQ),
        .SCCB_FREQ(SCCB_FREQ),
        .DEVICE_ID(8'h42),
        .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .SIOC     (SIOC),
        .SIOD_o   (SIOD_o),
        .SIOD_oe  (SIOD_oe),
        .ocupado  (ocupado),
        .pronto   (pronto),
        .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] tab_sub [0:6] = '{8'h12, 8'h11, 8'h12, 8'h40, 8'h8C, 8'h0C, 8'h3E};
    logic [7:0] tab_dat [0:6] = '{8'h80, 8'h01, 8'h14, 8'hD0, 8'h00, 8'h04, 8'h19};

    int checks = 0;
    int errors = 0;
    bit model_on = 0;
    int model_t  = 0;

    int         n_rise, n_stop, nbits;
    logic [26:0] sr;
    logic [7:0] first_byte;
    logic       ack9_oe;
    int         start_cyc, stop_end_cyc;
    bit         stop_end_valid;

    // clock offset of write w from the start pulse
    function automatic int write_offset(input int w);
        return w * SLOT_CLK + ((w > 0) ? DELAY_CLK : 0);
    endfunction

    // expected {SIOC, SIOD_o, SIOD_oe, ocupado, pronto, db_estado} t clocks after start
    function automatic logic [8:0] model_out(input int t);
        logic       sc, sd, oe, busy, done;
        logic [3:0] st;
        logic [23:0] trip;
        int rel, w, len, c, k, pos;
        sc = 1'b1; sd = 1'b1; oe = 1'b1; busy = 1'b1; done = 1'b0; st = 4'd5;
        rel = t;
        w = 0;
        for (int i = 0; i < 7; i++) begin
            len = SLOT_CLK + ((i == 0) ? DELAY_CLK : 0);
            if (w == i && rel >= len) begin
                rel = rel - len;
                w = i + 1;
            end
        end
        if (w == 7) begin
            busy = 1'b0;
            done = 1'b1;
            st = (rel == 0) ? 4'd6 : 4'd0;
        end else if (rel < 2 * Q) begin
            st = 4'd1;
            sd = 1'b0;
        end else if (rel < 110 * Q) begin
            c    = rel / Q - 2;
            pos  = (c / 4) % 9;
            sc   = ((c % 4) >= 2);
            trip = {8'h42, tab_sub[w], tab_dat[w]};
            if (pos == 8) begin
                st = 4'd3;
                oe = 1'b0;
            end else begin
                st = 4'd2;
                sd = trip[23 - 8 * (c / 36) - pos];
            end
        end else if (rel < WRITE_CLK) begin
            st = 4'd4;
            k  = rel / Q - 110;
            sc = (k >= 1);
            sd = (k == 2);
        end else if (rel < WRITE_CLK + ((w == 0) ? DELAY_CLK : 0)) begin
            st = 4'd7;
        end
        return {sc, sd, oe, busy, done, st};
    endfunction

    // every-cycle comparison of the DUT outputs against the timeline model
    initial begin
        logic [8:0] exp_v, act_v;
        forever begin
            @(negedge clock);
            if (model_on) begin
                exp_v = model_out(model_t);
                act_v = {SIOC, SIOD_o, SIOD_oe, ocupado, pronto, db_estado};
                if (!exp_v[6]) act_v[7] = exp_v[7];
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL timeline t=%0d: got %b expected %b (SIOC,SIOD_o,SIOD_oe,ocupado,pronto,db_estado)",
                             model_t, act_v, exp_v);
                end
                model_t++;
            end
        end
    end

    // SCCB bus decoder plus state-timing checks
    initial begin
        logic prev_sc, prev_line, line;
        logic [3:0] prev_db;
        logic [23:0] got, want;
        bit ok;
        int cyc, exp_gap;
        prev_sc = 1'b1; prev_line = 1'b1; prev_db = 4'd0; cyc = 0;
        forever begin
            @(negedge clock);
            cyc++;
            line = SIOD_oe ? SIOD_o : 1'b1;
            if (!prev_sc && SIOC && nbits < 27) begin
                n_rise++;
                sr = {sr[25:0], line};
                nbits++;
                if (nbits == 8 && n_stop == 0) first_byte = sr[7:0];
                if (nbits == 9 && n_stop == 0) ack9_oe = SIOD_oe;
            end
            if (prev_sc && SIOC && prev_line && !line) begin
                nbits = 0;
                sr = '0;
            end
            if (prev_sc && SIOC && !prev_line && line) begin
                got = {sr[26:19], sr[17:10], sr[8:1]};
                if (n_stop < 7) want = {8'h42, tab_sub[n_stop], tab_dat[n_stop]};
                else want = 24'h0;
                ok = (nbits == 27) && (n_stop < 7) && (got == want);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL decoded_write %0d: got %h (%0d bits) expected %h (27 bits)",
                             n_stop, got, nbits, want);
                end
                n_stop++;
            end
            if (db_estado == 4'd1 && prev_db != 4'd1) begin
                if (prev_db == 4'd5 && stop_end_valid) begin
                    exp_gap = GAP_TICKS * Q + ((n_stop == 1) ? DELAY_CLK : 0);
                    checks++;
                    if (cyc - stop_end_cyc != exp_gap) begin
                        errors++;
                        $display("FAIL gap_len after write %0d: got %0d clocks expected %0d",
                                 n_stop - 1, cyc - stop_end_cyc, exp_gap);
                    end
                end
                start_cyc = cyc;
            end
            if (prev_db == 4'd4 && (db_estado == 4'd5 || db_estado == 4'd7)) begin
                stop_end_cyc = cyc;
                stop_end_valid = 1'b1;
                checks++;
                if (cyc - start_cyc != WRITE_CLK) begin
                    errors++;
                    $display("FAIL write_span: got %0d clocks expected %0d", cyc - start_cyc, WRITE_CLK);
                end
            end
            prev_sc = SIOC;
            prev_line = line;
            prev_db = db_estado;
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic arm();
        @(negedge clock);
        iniciar = 1'b1;
        @(posedge clock);
        model_t = 0;
        model_on = 1'b1;
        n_rise = 0;
        n_stop = 0;
        nbits = 0;
        sr = '0;
        stop_end_valid = 1'b0;
        first_byte = 8'h00;
        ack9_oe = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic end_checks(input string run);
        check_lit({run, "_stops"}, n_stop, 7);
        check_lit({run, "_bit_clocks"}, n_rise, 189);
        check_lit({run, "_pronto_ocupado_estado"}, {pronto, ocupado, db_estado}, 6'b10_0000);
    endtask

    initial begin
        int t3, m, w;
        reset = 1'b0;
        iniciar = 1'b0;
        n_rise = 0; n_stop = 0; nbits = 0; sr = '0;
        stop_end_valid = 1'b0; start_cyc = 0; stop_end_cyc = 0;
        first_byte = 8'h00; ack9_oe = 1'b1;

        repeat (3) @(negedge clock);
        check_lit("reset_state", {SIOC, SIOD_o, SIOD_oe, ocupado, pronto, db_estado}, 9'b111_00_0000);
        reset = 1'b1;
        repeat ($urandom_range(2, 20)) @(negedge clock);
        check_lit("idle_before_start", {SIOC, SIOD_o, SIOD_oe, ocupado, pronto, db_estado}, 9'b111_00_0000);

        // run A: plain full table
        arm();
        repeat (RUN_CLK + 5) @(negedge clock);
        end_checks("runA");
        check_lit("first_byte_device_id", first_byte, 8'h42);
        check_lit("ninth_bit_released", ack9_oe, 1'b0);

        // run B: restart from pronto=1, stray iniciar pulses during write 3
        repeat ($urandom_range(1, 30)) @(negedge clock);
        check_lit("pronto_held_idle", {pronto, ocupado}, 2'b10);
        arm();
        t3 = write_offset(3) + $urandom_range(Q, WRITE_CLK - Q);
        repeat (t3) @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        repeat (RUN_CLK + 5 - t3 - 1) @(negedge clock);
        end_checks("runB");

        // run C: reset in the middle of a data bit, then a fresh start
        repeat ($urandom_range(1, 30)) @(negedge clock);
        arm();
        w = $urandom_range(0, 6);
        m = write_offset(w) + (2 + 36 * $urandom_range(0, 2) + 4 * $urandom_range(0, 7)) * Q
            + $urandom_range(0, 4 * Q - 1);
        repeat (m) @(negedge clock);
        check_lit("in_bit_before_reset", db_estado, 4'd2);
        model_on = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check_lit("reset_mid_bit", {SIOC, SIOD_o, SIOD_oe, ocupado, pronto, db_estado}, 9'b111_00_0000);
        reset = 1'b1;
        repeat (3 * Q) @(negedge clock);
        check_lit("idle_after_abort", {SIOC, SIOD_o, SIOD_oe, ocupado, pronto, db_estado}, 9'b111_00_0000);
        arm();
        repeat (RUN_CLK + 5) @(negedge clock);
        end_checks("runC");
        check_lit("restart_first_byte", first_byte, 8'h42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
